// File: rtl/lfsr_arbiter.sv
// rtl/lfsr_arbiter.sv - round-robin arbiter sequencing an external LFSR generator; optional GEN timeout under LFSR_ARB_TIMEOUT_EN
module lfsr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEQ_W   = 288,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ack,
  input  logic               gen_done,
  input  logic [SEQ_W-1:0]   gen_sequence,
  output logic               gen_clear,
  output logic               gen_enable,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid,
  output logic [SEQ_W-1:0]   seq_out,
  output logic               busy,
  output logic               error
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_GEN     = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t        state;
  logic [OW-1:0] last_owner;
  logic [OW-1:0] owner;
  logic [OW-1:0] pick;
  logic          dropped;
  logic          owner_req;
  logic          timeout_hit;

  assign owner_req = req[owner];

  // Pick the first requester after the previous owner, wrapping at NUM_REQ-1
  always_comb begin
    int   idx;
    logic hit;
    idx  = 0;
    hit  = 1'b0;
    pick = last_owner;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && req[idx[OW-1:0]]) begin
        hit  = 1'b1;
        pick = idx[OW-1:0];
      end
    end
  end

  // Transaction FSM: arbitrate, restart the generator, run it, hand the sequence over
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_owner <= OW'(NUM_REQ - 1);
      owner      <= '0;
      dropped    <= 1'b0;
      grant      <= '0;
      valid      <= 1'b0;
      gen_clear  <= 1'b0;
      gen_enable <= 1'b0;
      busy       <= 1'b0;
      seq_out    <= '0;
    end else begin
      gen_clear <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner     <= pick;
            grant     <= NUM_REQ'(1) << pick;
            gen_clear <= 1'b1;
            busy      <= 1'b1;
            dropped   <= 1'b0;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // a done flag left over from the previous run is not looked at here
          gen_enable <= 1'b1;
          if (!owner_req) dropped <= 1'b1;
          state <= S_GEN;
        end
        S_GEN: begin
          if (!owner_req) dropped <= 1'b1;
          if (gen_done) begin
            gen_enable <= 1'b0;
            if (dropped || !owner_req) begin
              // requester walked away: let the run finish, then throw the result away
              grant      <= '0;
              busy       <= 1'b0;
              last_owner <= owner;
              state      <= S_IDLE;
            end else begin
              seq_out <= gen_sequence;
              valid   <= 1'b1;
              state   <= S_DELIVER;
            end
          end else if (timeout_hit) begin
            gen_enable <= 1'b0;
            grant      <= '0;
            busy       <= 1'b0;
            last_owner <= owner;
            state      <= S_IDLE;
          end
        end
        S_DELIVER: begin
          if (ack[owner]) begin
            valid      <= 1'b0;
            grant      <= '0;
            busy       <= 1'b0;
            last_owner <= owner;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LFSR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;

  assign timeout_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // Count cycles spent in GEN and flag the cycle the abort happens
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      error   <= 1'b0;
    end else begin
      error <= (state == S_GEN) && !gen_done && timeout_hit;
      if (state == S_GEN) tmo_cnt <= tmo_cnt + 1'b1;
      else                tmo_cnt <= '0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign error          = 1'b0;
`endif

endmodule

// File: doc/lfsr_arbiter.md
LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter SEQ_W, default 288: width of the random sequence delivered per grant.
REQ-003 Parameter TIMEOUT, default 200: maximum GEN-state cycles before abort (used only under REQ-025).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester level request for one random sequence.
REQ-007 ack  input  NUM_REQ  per-requester acknowledge that the delivered sequence was taken.
REQ-008 gen_done  input  1  generator completion flag.
REQ-009 gen_sequence  input  SEQ_W  generator output, valid while gen_done=1.
REQ-010 gen_clear  output  1  one-cycle restart pulse to the generator's synchronous counter reset.
REQ-011 gen_enable  output  1  generator shift enable.
REQ-012 grant  output  NUM_REQ  one-hot owner of the current transaction; all zero when idle.
REQ-013 valid  output  1  seq_out holds a sequence for the granted requester.
REQ-014 seq_out  output  SEQ_W  registered sequence captured from gen_sequence.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 error  output  1  one-cycle timeout abort pulse; constant 0 when REQ-025 is compiled out.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, GEN and DELIVER; all outputs SHALL be registered.
- IDLE: if req is nonzero, select a requester round-robin, starting at the index after last_owner and wrapping NUM_REQ-1 to 0; load grant; go to CLEAR.
- CLEAR: gen_clear=1 and gen_enable=0 for exactly one cycle; then go to GEN.
- GEN: gen_enable=1 every cycle; on gen_done=1, capture gen_sequence into seq_out, drop gen_enable and go to DELIVER on the same edge.
- DELIVER: valid=1 and grant held; on ack[owner]=1, drop valid, clear grant, set last_owner=owner and return to IDLE.
REQ-018 gen_done SHALL be ignored outside GEN, including a stale gen_done=1 seen in the CLEAR cycle.
REQ-019 ack bits of non-owners and any ack outside DELIVER SHALL be ignored.
REQ-020 If req[owner] drops during CLEAR or GEN, generation SHALL run to gen_done; the sequence SHALL then be discarded (valid stays 0), last_owner updated, and the FSM SHALL return to IDLE.
REQ-021 req changes during DELIVER SHALL NOT affect the current owner; new requests SHALL wait for IDLE.
REQ-022 Arbitration SHALL take one cycle. Minimum request-to-valid latency = 2 + (generator cycles to done). Exactly one requester SHALL be served per transaction.
REQ-023 After reset, last_owner = NUM_REQ-1, so requester 0 has first priority.

Reset
REQ-024 reset SHALL immediately force state=IDLE, grant=0, valid=0, gen_clear=0, gen_enable=0, busy=0, error=0, seq_out=0 and last_owner=NUM_REQ-1. Reset mid-transaction SHALL abandon the transaction with no delivery.

Configuration
REQ-025 Macro LFSR_ARB_TIMEOUT_EN.
- Defined: a GEN cycle counter SHALL be kept. If TIMEOUT cycles elapse without gen_done, the block SHALL pulse error for one cycle, set last_owner=owner and go to IDLE with no delivery.
- Undefined: GEN SHALL wait indefinitely, no counter SHALL be built, and error SHALL be tied to 0.

Verification
REQ-026 The bench SHALL cover these scenarios:
- req=0001, generator model asserts done 127 enable cycles after clear, done data=0xA5 pattern -> gen_clear for 1 cycle, 127 gen_enable cycles, valid with grant=0001 and seq_out=pattern; ack -> idle.
- req=1111 held constantly -> grants in order 0001, 0010, 0100, 1000, 0001.
- req[2] drops mid-GEN -> no valid; next grant goes to index 3 if requesting.
- reset asserted mid-GEN -> all outputs 0 asynchronously; after release, req=0010 -> grant=0010.
- With LFSR_ARB_TIMEOUT_EN and TIMEOUT=200, gen_done never asserted -> error pulse 200 cycles after GEN entry, busy=0 next cycle.
- In DELIVER, ack=0100 while owner=0001 -> valid stays high until ack[0]=1.
